// File: rtl/fft_bitrev_reader_if.sv
// fft_bitrev_reader_if: sample RAM read port and natural-order output stream
interface fft_bitrev_reader_if #(parameter int ADDR_W = 5, parameter int DATA_W = 32);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;
  modport master (output rd_en, rd_addr, out_valid, out_data, out_index, out_last,
                  input  rd_data, out_ready);
  modport slave  (input  rd_en, rd_addr, out_valid, out_data, out_index, out_last,
                  output rd_data, out_ready);
endinterface

// File: rtl/fft_bitrev_reader.sv
// fft_bitrev_reader: reads one frame from the sample RAM in bit-reversed order and streams it out
// in natural order through a 2-entry buffer that absorbs the one-cycle RAM latency.
module fft_bitrev_reader #(parameter int ADDR_W = 5, parameter int DATA_W = 32) (
  input  logic clk,
  input  logic clr_n,
  input  logic en,
  input  logic start,
  output logic busy,
  output logic done,
  fft_bitrev_reader_if.master bus
);
  localparam int EW = ADDR_W + DATA_W;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            r_state, w_next;
  logic [ADDR_W:0]   r_k_iss;
  logic [ADDR_W-1:0] r_k_out, r_tag, r_addr, w_rev;
  logic              r_inflight;
  logic [1:0]        r_cnt;
  logic [EW-1:0]     r_s0, r_s1, w_in, w_head;
  logic              w_go, w_pop, w_credit, w_issue;
  for (genvar i = 0; i < ADDR_W; i++) begin : g_rev
    assign w_rev[i] = r_k_iss[ADDR_W-1-i];
  end
  assign w_go  = (r_state == IDLE) & start & en;
  assign w_in  = {r_tag, bus.rd_data};
  // RAM data landing into an empty buffer is presented the same cycle it arrives
  assign w_head        = (r_cnt == 2'd0 && r_inflight) ? w_in : r_s0;
  assign bus.out_valid = (r_cnt != 2'd0) | r_inflight;
  assign w_pop         = bus.out_valid & bus.out_ready;
  assign w_credit      = ({1'b0, r_cnt} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop});
  assign w_issue       = (r_state == RUN) & ~r_k_iss[ADDR_W] & en & w_credit;
  assign bus.rd_en     = w_issue;
  assign bus.rd_addr   = w_issue ? w_rev : r_addr;
  assign {bus.out_index, bus.out_data} = w_head;
  assign bus.out_last  = bus.out_valid & (w_head[EW-1:DATA_W] == '1);
  assign busy = r_state == RUN;
  assign done = r_state == DONE;
  always_comb begin
    w_next = (r_state == IDLE) ? (w_go ? RUN : IDLE) :
             (r_state == RUN)  ? ((w_pop && r_k_out == '1) ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_k_iss    <= '0;
      r_k_out    <= '0;
      r_tag      <= '0;
      r_addr     <= '0;
      r_inflight <= 1'b0;
      r_cnt      <= '0;
      r_s0       <= '0;
      r_s1       <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_tag  <= r_k_iss[ADDR_W-1:0];
        r_addr <= w_rev;
      end
      r_k_iss <= w_go ? '0 : r_k_iss + (ADDR_W+1)'(w_issue);
      r_k_out <= w_go ? '0 : r_k_out + ADDR_W'(w_pop);
      r_cnt   <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
      // credit guarantees no arrival while two entries are held
      if (w_pop && r_cnt == 2'd2) r_s0 <= r_s1;
      else if (r_inflight && (r_cnt == 2'd0 || (w_pop && r_cnt == 2'd1))) r_s0 <= w_in;
      if (r_inflight) r_s1 <= w_in;
    end
  end
endmodule

// File: tb/tb_fft_bitrev_reader.sv
// tb_fft_bitrev_reader: directed frames with a beat scoreboard, backpressure, enable gaps,
// ignored starts, mid-frame reset and back-to-back frames.
module tb_fft_bitrev_reader;
  logic clk, clr_n, en, start, busy, done;
  logic [31:0] rd_q;
  logic [35:0] sb[$];
  int passed, total, cyc, done_cnt, done_cyc, first_valid_cyc, last_cyc, outst, t0, lat, dc, n;
  logic busy_at_done, prev_stall, en_low_chk;
  logic [35:0] prev_head;

  fft_bitrev_reader_if #(.ADDR_W(3), .DATA_W(32)) bus();
  fft_bitrev_reader #(.ADDR_W(3), .DATA_W(32)) dut (
    .clk(clk), .clr_n(clr_n), .en(en), .start(start), .busy(busy), .done(done), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.rd_en) rd_q <= {29'b0, bus.rd_addr};
  assign bus.rd_data = rd_q;

  function automatic logic [2:0] br(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    logic w;
    logic [35:0] h, e;
    @(negedge clk);
    cyc++;
    h = {bus.out_last, bus.out_index, bus.out_data};
    w = bus.out_valid & bus.out_ready;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
    if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (prev_stall) chk("head_hold", h, prev_head);
    if (w) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("beat", h, e);
        if (bus.out_last) last_cyc = cyc;
      end
    end
    if (en_low_chk) chk("rd_en_gated", bus.rd_en, 0);
    outst = outst + int'(bus.rd_en) - int'(w);
    chk("outstanding_le2", outst <= 2, 1);
    prev_stall = bus.out_valid & ~bus.out_ready;
    prev_head = h;
    @(posedge clk);
    #1;
  endtask

  task automatic frame_start();
    for (int k = 0; k < 8; k++) sb.push_back({k == 7, 3'(k), 29'b0, br(3'(k))});
    first_valid_cyc = -1;
    dc = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int budget, output int l);
    l = -1;
    for (int i = 0; i < budget && l < 0; i++) begin
      tick();
      if (done_cyc == cyc) l = cyc - t0;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, bus.rd_en, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_last"}, bus.out_last, 0);
    chk({tag, "_rd_addr"}, bus.rd_addr, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_out_index"}, bus.out_index, 0);
  endtask

  initial begin
    passed = 0; total = 0; cyc = 0; done_cnt = 0; done_cyc = -1; outst = 0;
    first_valid_cyc = -1; last_cyc = -1; busy_at_done = 1'b1;
    prev_stall = 1'b0; en_low_chk = 1'b0; prev_head = '0;
    clr_n = 1'b0; en = 1'b0; start = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    clr_n = 1'b1; en = 1'b1; bus.out_ready = 1'b1;
    tick(); tick();
    chk("idle_busy", busy, 0);

    // full-rate frame
    frame_start();
    chk("busy_after_start", busy, 1);
    chk("first_rd_en", bus.rd_en, 1);
    chk("first_rd_addr", bus.rd_addr, 0);
    wait_done(40, lat);
    chk("latency", lat, 10);
    chk("first_valid_delay", first_valid_cyc - t0, 2);
    chk("last_beat_delay", last_cyc - t0, 9);
    chk("busy_at_done", busy_at_done, 0);
    chk("frame1_drained", sb.size(), 0);

    // start right after done
    frame_start();
    chk("b2b_rd_en", bus.rd_en, 1);
    chk("b2b_rd_addr", bus.rd_addr, 0);
    wait_done(40, lat);
    chk("b2b_latency", lat, 10);
    chk("b2b_drained", sb.size(), 0);

    // backpressure from beat 2
    tick();
    frame_start();
    for (int i = 0; i < 20 && sb.size() > 6; i++) tick();
    bus.out_ready = 1'b0;
    repeat (5) tick();
    chk("stall_outstanding", outst, 2);
    chk("stall_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    wait_done(60, lat);
    chk("bp_done", lat > 0, 1);
    chk("bp_drained", sb.size(), 0);
    chk("bp_one_done", done_cnt - dc, 1);

    // enable gap mid-frame
    tick();
    frame_start();
    repeat (3) tick();
    n = sb.size();
    en = 1'b0; en_low_chk = 1'b1;
    repeat (4) tick();
    chk("en_low_drain", (n - sb.size()) >= 1, 1);
    en = 1'b1; en_low_chk = 1'b0;
    wait_done(60, lat);
    chk("en_done", lat > 0, 1);
    chk("en_drained", sb.size(), 0);

    // start held through RUN and DONE
    tick();
    frame_start();
    start = 1'b1;
    wait_done(40, lat);
    start = 1'b0;
    repeat (3) tick();
    chk("held_start_latency", lat, 10);
    chk("held_start_one_done", done_cnt - dc, 1);
    chk("held_start_idle", busy, 0);
    chk("held_start_drained", sb.size(), 0);

    // reset at beat 3
    tick();
    frame_start();
    for (int i = 0; i < 20 && sb.size() > 5; i++) tick();
    clr_n = 1'b0;
    #1;
    check_zero("midreset");
    sb.delete();
    outst = 0;
    prev_stall = 1'b0;
    tick();
    clr_n = 1'b1;
    repeat (2) tick();
    chk("post_reset_idle", busy, 0);
    chk("post_reset_no_valid", bus.out_valid, 0);
    frame_start();
    chk("post_reset_rd_addr", bus.rd_addr, 0);
    wait_done(40, lat);
    chk("post_reset_latency", lat, 10);
    chk("post_reset_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
